// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants for the horizontal/vertical counters
// and the sync decoder, plus the common counter width and column type.
package vga_timing_pkg;

  localparam int COUNT_W  = 10;
  localparam int DIV_W    = 4;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/pix_tick_div.sv
// Pixel-rate strobe generator: divides clk by DIV while run is high and
// emits a one-clk pix_tick on the last phase of each pixel period.
module pix_tick_div
  import vga_timing_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic pix_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Divider phase: advances only while running, wraps after the last phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Strobe is a decode of the phase register, gated by run; held low during
  // reset so a DIV=1 build does not tick while the counters are cleared.
  assign pix_tick = run & ~reset & (div_cnt == DIV_LAST);

endmodule

// File: rtl/h_counter.sv
// Horizontal timing stage: counts pixel columns 0..H_TOTAL-1 at the pixel
// rate and produces hsync, h_video_on and the end-of-line enable_v pulse
// for the downstream vertical counter.
module h_counter
  import vga_timing_pkg::*;
#(
  parameter int   DIV       = 4,
  parameter int   H_ACTIVE  = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP      = vga_timing_pkg::H_FP,
  parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int   H_BP      = vga_timing_pkg::H_BP,
  parameter logic HSYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               pix_tick,
  output logic [COUNT_W-1:0] h_count,
  output logic               enable_v,
  output logic               hsync,
  output logic               h_video_on
);

  localparam int     H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam count_t H_LAST   = count_t'(H_TOTAL - 1);
  localparam count_t HS_FIRST = count_t'(H_ACTIVE + H_FP);
  localparam count_t HS_LAST  = count_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam count_t VID_END  = count_t'(H_ACTIVE);

  count_t h_next;

  // Sync level for a given column; asserted level is HSYNC_POL
  function automatic logic hsync_level(input count_t col);
    return ((col >= HS_FIRST) && (col <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
  endfunction

  pix_tick_div #(
    .DIV      (DIV)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .pix_tick (pix_tick)
  );

  // Column the counter moves to on the next pixel tick
  always_comb begin
    h_next = (h_count == H_LAST) ? '0 : h_count + count_t'(1);
  end

  // End of line: the same edge that wraps h_count advances the vertical
  // counter, so the two stay aligned without an extra register.
  assign enable_v = pix_tick & (h_count == H_LAST);

  // Column counter and its decodes; sync/video are decoded from h_next so
  // they change on the same edge as h_count with no lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count    <= '0;
      hsync      <= ~HSYNC_POL;
      h_video_on <= 1'b1;
    end else if (pix_tick) begin
      h_count    <= h_next;
      hsync      <= hsync_level(h_next);
      h_video_on <= (h_next < VID_END);
    end
  end

endmodule
